// File: rtl/wordle_pkg.sv
// rtl/wordle_pkg.sv - shared row-format constants, state encoding and slot helper
package wordle_pkg;

  localparam int ROW_W    = 35;
  localparam int SLOT_W   = 7;
  localparam int WORD_LEN = 5;

  localparam logic [4:0] LTR_BLANK = 5'd0;
  localparam logic [4:0] LTR_A     = 5'd1;
  localparam logic [4:0] LTR_Z     = 5'd26;

  localparam logic [2:0] CNT_FULL = 3'(WORD_LEN);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_COMMIT = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Bit offset of slot s inside a row.
  function automatic logic [5:0] slot_off(input logic [2:0] s);
    return 6'(s) * 6'(SLOT_W);
  endfunction

endpackage

// File: rtl/row_all_green.sv
// rtl/row_all_green.sv - flags a row whose five green bits are all set
module row_all_green
  import wordle_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  output logic             all_green_o
);

  always_comb begin
    all_green_o = 1'b1;
    for (int s = 0; s < WORD_LEN; s++) begin
      all_green_o = all_green_o & row_i[s*SLOT_W + 5];
    end
  end

endmodule

// File: rtl/guess_row_builder.sv
// rtl/guess_row_builder.sv - builds guess rows from key events and hands them to the scorer
// Optional win detection: GUESS_ROW_WIN_DETECT_EN
module guess_row_builder
  import wordle_pkg::*;
#(
  parameter int MAX_GUESSES = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_code,
  input  logic             key_bksp,
  input  logic             key_enter,
  output logic [ROW_W-1:0] row_out,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [2:0]       row_index,
  output logic [2:0]       letter_count,
  output logic             bad_enter,
  output logic             game_over
`ifdef GUESS_ROW_WIN_DETECT_EN
  ,
  input  logic [ROW_W-1:0] scored_row,
  input  logic             scored_valid,
  output logic             win
`endif
);

  localparam logic [2:0] LAST_IDX = 3'(MAX_GUESSES - 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic              bad_q, bad_d;
  logic              go_q, go_d;
  logic [2:0]        slot_add, slot_del;
  logic              letter_ok;

  // First typed letter lands in slot 4, so slots fill from the top down.
  assign slot_add  = 3'd4 - cnt_q;
  assign slot_del  = 3'd5 - cnt_q;
  assign letter_ok = (key_code >= LTR_A) && (key_code <= LTR_Z);

`ifdef GUESS_ROW_WIN_DETECT_EN
  logic win_q, win_d;
  logic all_green;

  row_all_green u_all_green (
    .row_i       (scored_row),
    .all_green_o (all_green)
  );
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bad_d   = 1'b0;
    go_d    = go_q;
`ifdef GUESS_ROW_WIN_DETECT_EN
    win_d   = win_q;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (key_valid) begin
          if (key_enter) begin
            if (cnt_q == CNT_FULL) state_d = ST_COMMIT;
            else                   bad_d   = 1'b1;
          end else if (key_bksp) begin
            if (cnt_q != 3'd0) begin
              cnt_d = cnt_q - 3'd1;
              row_d[slot_off(slot_del) +: SLOT_W] = '0;
            end
          end else if (letter_ok && (cnt_q < CNT_FULL)) begin
            cnt_d = cnt_q + 3'd1;
            row_d[slot_off(slot_add) +: SLOT_W] = {2'b00, key_code};
          end
        end
      end
      ST_COMMIT: begin
        if (row_ready) begin
          row_d = '0;
          cnt_d = 3'd0;
          if (idx_q == LAST_IDX) begin
            go_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_ENTRY;
          end
        end
      end
      default: begin
      end
    endcase
`ifdef GUESS_ROW_WIN_DETECT_EN
    // A winning score overrides whatever the key path decided this cycle.
    if (scored_valid && all_green) begin
      win_d   = 1'b1;
      go_d    = 1'b1;
      state_d = ST_DONE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ENTRY;
      row_q   <= '0;
      cnt_q   <= 3'd0;
      idx_q   <= 3'd0;
      bad_q   <= 1'b0;
      go_q    <= 1'b0;
`ifdef GUESS_ROW_WIN_DETECT_EN
      win_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      go_q    <= go_d;
`ifdef GUESS_ROW_WIN_DETECT_EN
      win_q   <= win_d;
`endif
    end
  end

  assign row_out      = row_q;
  assign row_valid    = (state_q == ST_COMMIT);
  assign row_index    = idx_q;
  assign letter_count = cnt_q;
  assign bad_enter    = bad_q;
  assign game_over    = go_q;
`ifdef GUESS_ROW_WIN_DETECT_EN
  assign win          = win_q;
`endif

endmodule

// File: tb/tb_guess_row_builder.sv
// tb/tb_guess_row_builder.sv - table, directed and random checks of guess_row_builder
module tb_guess_row_builder;

  localparam int MAXG = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = 5'd0;
  logic        key_bksp = 1'b0;
  logic        key_enter = 1'b0;
  logic        row_ready = 1'b0;
  logic [34:0] row_out;
  logic        row_valid;
  logic [2:0]  row_index;
  logic [2:0]  letter_count;
  logic        bad_enter;
  logic        game_over;
`ifdef GUESS_ROW_WIN_DETECT_EN
  logic [34:0] scored_row = '0;
  logic        scored_valid = 1'b0;
  logic        win;
`endif

  int ntotal = 0;
  int nbad   = 0;

  guess_row_builder #(.MAX_GUESSES(MAXG)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_bksp     (key_bksp),
    .key_enter    (key_enter),
    .row_out      (row_out),
    .row_valid    (row_valid),
    .row_ready    (row_ready),
    .row_index    (row_index),
    .letter_count (letter_count),
    .bad_enter    (bad_enter),
    .game_over    (game_over)
`ifdef GUESS_ROW_WIN_DETECT_EN
    ,
    .scored_row   (scored_row),
    .scored_valid (scored_valid),
    .win          (win)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: typed letters as a queue, game phase as flags.
  logic [4:0] m_q[$];
  bit         m_commit, m_done, m_bad, m_go;
  int         m_idx;

  function automatic logic [34:0] model_row();
    logic [34:0] r = '0;
    foreach (m_q[i]) r = r | (35'(m_q[i]) << (7 * (4 - i)));
    return r;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_q.delete(); m_commit = 0; m_done = 0; m_bad = 0; m_go = 0; m_idx = 0;
    end else begin
      m_bad = 0;
      if (m_done) begin
      end else if (m_commit) begin
        if (row_ready) begin
          m_q.delete();
          m_commit = 0;
          if (m_idx == MAXG - 1) begin m_go = 1; m_done = 1; end
          else m_idx++;
        end
      end else if (key_valid) begin
        if (key_enter) begin
          if (m_q.size() == 5) m_commit = 1;
          else m_bad = 1;
        end else if (key_bksp) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (key_code >= 1 && key_code <= 26 && m_q.size() < 5) begin
          m_q.push_back(key_code);
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    ntotal++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("mdl_row",   row_out,             model_row());
    chk("mdl_valid", 35'(row_valid),      35'(m_commit));
    chk("mdl_idx",   35'(row_index),      35'(m_idx));
    chk("mdl_cnt",   35'(letter_count),   35'(m_q.size()));
    chk("mdl_bad",   35'(bad_enter),      35'(m_bad));
    chk("mdl_go",    35'(game_over),      35'(m_go));
  endtask

  task automatic press(input logic kv, input logic [4:0] c, input logic b, input logic e);
    key_valid = kv; key_code = c; key_bksp = b; key_enter = e;
    step();
    key_valid = 0; key_bksp = 0; key_enter = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic type_word(input logic [4:0] a, b, c, d, e);
    press(1, a, 0, 0); press(1, b, 0, 0); press(1, c, 0, 0);
    press(1, d, 0, 0); press(1, e, 0, 0);
  endtask

  function automatic logic [34:0] mk(input logic [4:0] a, b, c, d, e);
    return {2'b00, a, 2'b00, b, 2'b00, c, 2'b00, d, 2'b00, e};
  endfunction

  typedef struct {
    logic        kv;
    logic [4:0]  code;
    logic        bk;
    logic        en;
    logic        rdy;
    logic [2:0]  cnt;
    logic        vld;
    logic        bad;
    logic [2:0]  idx;
    logic [34:0] row;
  } vec_t;

  function automatic vec_t v(input logic kv, input logic [4:0] code, input logic bk,
                             input logic en, input logic rdy, input logic [2:0] cnt,
                             input logic vld, input logic bad, input logic [2:0] idx,
                             input logic [34:0] row);
    vec_t t;
    t.kv = kv; t.code = code; t.bk = bk; t.en = en; t.rdy = rdy;
    t.cnt = cnt; t.vld = vld; t.bad = bad; t.idx = idx; t.row = row;
    return t;
  endfunction

  vec_t tbl[21];

  initial begin
    logic [34:0] crane;
    logic [34:0] word;
    crane = mk(5'd3, 5'd18, 5'd1, 5'd14, 5'd5);
    tbl[0]  = v(1, 3,  0, 0, 0, 1, 0, 0, 0, mk(3, 0, 0, 0, 0));
    tbl[1]  = v(1, 18, 0, 0, 0, 2, 0, 0, 0, mk(3, 18, 0, 0, 0));
    tbl[2]  = v(1, 1,  0, 0, 0, 3, 0, 0, 0, mk(3, 18, 1, 0, 0));
    tbl[3]  = v(1, 14, 0, 0, 0, 4, 0, 0, 0, mk(3, 18, 1, 14, 0));
    tbl[4]  = v(1, 5,  0, 0, 0, 5, 0, 0, 0, crane);
    tbl[5]  = v(1, 7,  0, 0, 0, 5, 0, 0, 0, crane);
    tbl[6]  = v(1, 0,  0, 0, 0, 5, 0, 0, 0, crane);
    tbl[7]  = v(1, 27, 0, 0, 0, 5, 0, 0, 0, crane);
    tbl[8]  = v(1, 4,  0, 1, 1, 5, 1, 0, 0, crane);
    tbl[9]  = v(0, 0,  0, 0, 1, 0, 0, 0, 1, '0);
    tbl[10] = v(1, 9,  0, 0, 0, 1, 0, 0, 1, mk(9, 0, 0, 0, 0));
    tbl[11] = v(1, 9,  0, 1, 0, 1, 0, 1, 1, mk(9, 0, 0, 0, 0));
    tbl[12] = v(0, 0,  0, 0, 0, 1, 0, 0, 1, mk(9, 0, 0, 0, 0));
    tbl[13] = v(1, 9,  1, 0, 0, 0, 0, 0, 1, '0);
    tbl[14] = v(1, 9,  1, 0, 0, 0, 0, 0, 1, '0);
    tbl[15] = v(1, 2,  0, 0, 0, 1, 0, 0, 1, mk(2, 0, 0, 0, 0));
    tbl[16] = v(1, 3,  0, 0, 0, 2, 0, 0, 1, mk(2, 3, 0, 0, 0));
    tbl[17] = v(1, 4,  0, 0, 0, 3, 0, 0, 1, mk(2, 3, 4, 0, 0));
    tbl[18] = v(1, 4,  1, 0, 0, 2, 0, 0, 1, mk(2, 3, 0, 0, 0));
    tbl[19] = v(1, 4,  1, 0, 0, 1, 0, 0, 1, mk(2, 0, 0, 0, 0));
    tbl[20] = v(1, 4,  1, 1, 0, 1, 0, 1, 1, mk(2, 0, 0, 0, 0));

    // Reset state
    do_reset();
    chk("rst_row",   row_out,           '0);
    chk("rst_valid", 35'(row_valid),    35'd0);
    chk("rst_idx",   35'(row_index),    35'd0);
    chk("rst_cnt",   35'(letter_count), 35'd0);
    chk("rst_go",    35'(game_over),    35'd0);

    // Table-driven sequence: CRANE with handshake, overflow, invalid codes, bksp, bad enter
    foreach (tbl[i]) begin
      key_valid = tbl[i].kv; key_code = tbl[i].code; key_bksp = tbl[i].bk;
      key_enter = tbl[i].en; row_ready = tbl[i].rdy;
      step();
      chk($sformatf("tbl%0d_cnt", i),   35'(letter_count), 35'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 35'(row_valid),    35'(tbl[i].vld));
      chk($sformatf("tbl%0d_bad", i),   35'(bad_enter),    35'(tbl[i].bad));
      chk($sformatf("tbl%0d_idx", i),   35'(row_index),    35'(tbl[i].idx));
      chk($sformatf("tbl%0d_row", i),   row_out,           tbl[i].row);
    end
    key_valid = 0; key_bksp = 0; key_enter = 0; row_ready = 0;

    // Backpressure: ready low for 10 cycles while keys arrive
    do_reset();
    word = mk(5'd8, 5'd5, 5'd12, 5'd12, 5'd15);
    type_word(8, 5, 12, 12, 15);
    press(1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      press(1, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("hold_row",   row_out,        word);
      chk("hold_valid", 35'(row_valid), 35'd1);
    end
    row_ready = 1;
    press(0, 0, 0, 0);
    chk("hold_xfer_valid", 35'(row_valid), 35'd0);
    chk("hold_xfer_idx",   35'(row_index), 35'd1);
    row_ready = 0;

    // Reset in the middle of the third row's COMMIT
    do_reset();
    row_ready = 1;
    for (int g = 0; g < 2; g++) begin
      type_word(1, 2, 3, 4, 5);
      press(1, 0, 0, 1);
      press(0, 0, 0, 0);
    end
    row_ready = 0;
    type_word(6, 7, 8, 9, 10);
    press(1, 0, 0, 1);
    press(0, 0, 0, 0);
    chk("midc_valid", 35'(row_valid), 35'd1);
    row_ready = 1; rst = 1;
    step();
    rst = 0; row_ready = 0;
    chk("midc_rst_valid", 35'(row_valid),    35'd0);
    chk("midc_rst_idx",   35'(row_index),    35'd0);
    chk("midc_rst_row",   row_out,           '0);
    chk("midc_rst_cnt",   35'(letter_count), 35'd0);

    // Exhaust all guesses
    do_reset();
    row_ready = 1;
    for (int g = 0; g < MAXG; g++) begin
      type_word(19, 20, 1, 18, 5);
      press(1, 0, 0, 1);
      press(0, 0, 0, 0);
    end
    chk("over_go",  35'(game_over), 35'd1);
    chk("over_idx", 35'(row_index), 35'(MAXG - 1));
    press(1, 7, 0, 0);
    press(1, 0, 0, 1);
    chk("over_cnt", 35'(letter_count), 35'd0);
    chk("over_bad", 35'(bad_enter),    35'd0);
    chk("over_row", row_out,           '0);
    row_ready = 0;

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst       = ($urandom_range(0, 299) == 0);
      key_valid = ($urandom_range(0, 9) < 7);
      r         = $urandom_range(0, 99);
      key_enter = (r < 12);
      key_bksp  = (r >= 12 && r < 27);
      key_code  = 5'($urandom_range(0, 31));
      row_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 0; key_valid = 0; key_bksp = 0; key_enter = 0; row_ready = 0;

`ifdef GUESS_ROW_WIN_DETECT_EN
    do_reset();
    row_ready = 1;
    type_word(1, 2, 3, 4, 5);
    press(1, 0, 0, 1);
    press(0, 0, 0, 0);
    row_ready = 0;
    scored_row = '0;
    for (int s = 0; s < 5; s++) scored_row[7*s + 5] = 1'b1;
    scored_valid = 1;
    @(posedge clk); #1;
    scored_valid = 0;
    chk("win_win", 35'(win),       35'd1);
    chk("win_go",  35'(game_over), 35'd1);
    key_valid = 1; key_code = 5'd3;
    @(posedge clk); #1;
    key_valid = 0;
    chk("win_cnt", 35'(letter_count), 35'd0);
    chk("win_sticky", 35'(win), 35'd1);
`endif

    $display("test done: total=%0d bad=%0d", ntotal, nbad);
    $finish;
  end

endmodule
